fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the decode stage and supplies it with `if_addr`/`if_inst` each cycle. It owns the fetch PC and runs a req/ack handshake with instruction memory. It honours pipeline stalls through a one-entry skid buffer, and redirects to branch targets one instruction late so the MIPS delay slot is always fetched. Exception redirects from CP0 take effect immediately.

## Interface
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `stall` in 1: decode cannot accept; hold outputs.
- `flush` in 1: exception redirect, single-cycle pulse.
- `exc_pc` in 32: handler address, valid with `flush`.
- `branch_flag` in 1: decode's branch-taken for the instruction on `if_inst`.
- `branch_addr` in 32: branch target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address; stable while `imem_req`=1 and no ack.
- `imem_ack` in 1: request completes this cycle.
- `imem_rdata` in 32: instruction; valid when `imem_ack`=1.
- `if_valid` out 1: `if_inst`/`if_addr` hold a real instruction.
- `if_addr` out 32: PC of `if_inst`.
- `if_inst` out 32: instruction to decode; 32'h0 (NOP) when `if_valid`=0.
- `if_stall_req` out 1: high while decode is starved (`if_valid`=0, not in reset).
- `if_addr_err` out 1: misaligned fetch reported (see Configuration).

## Operation
- Registers:
  - `fetch_pc`: the address currently requested.
  - Output register: `if_valid`, `if_addr`, `if_inst`.
  - Skid entry: valid, addr, inst.
  - `redir_pend` and `redir_addr`.
  - FSM state.
- FSM states:
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - HOLD: skid full, `imem_req`=0.
  - DROP: in-flight request is to be discarded; `imem_req`=1, same address.
- Acceptance: decode consumes the output register on any cycle with `stall`=0. The output register then loads the skid entry if valid, else `imem_rdata` on ack, else becomes invalid.
- Ack arriving while `stall`=1 and the output register is valid:
  - Data goes to the skid entry.
  - The FSM enters HOLD.
  - HOLD returns to FETCH once the skid has drained.
- Next fetch PC after an ack, highest priority first:
  - `branch_addr` if a branch is accepted the same cycle.
  - `redir_addr` if `redir_pend` is set (then clear `redir_pend`).
  - Otherwise `fetch_pc`+4.
- Branch accepted (`branch_flag` & `if_valid` & ~`stall`) with no ack that cycle: set `redir_pend`, latch `branch_addr`. The in-flight or next fetch is the delay slot and is kept.
- `flush` overrides `stall` and `branch_flag`:
  - Clears the output register, the skid entry and `redir_pend`.
  - Sets `fetch_pc`=`exc_pc`.
  - If a request is outstanding without an ack this cycle, enter DROP. DROP waits for the ack, discards the data, then moves to FETCH at `exc_pc`.
  - If the ack coincides with `flush`, its data is discarded and the next cycle is FETCH at `exc_pc`.
- A second `flush` while in DROP replaces the target address.
- `fetch_pc` arithmetic is modulo 2^32; it wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_addr`=0, `if_inst`=0, `if_stall_req`=0, `if_addr_err`=0, FSM=FETCH, skid and `redir_pend` empty.
- First request is asserted in the first cycle after `rst` deasserts.
- Latency: ack at edge N means the instruction appears on `if_inst` after edge N. The output is registered; there is no combinational path from `imem_rdata`.
- Throughput: one instruction per cycle with same-cycle acks.
- Redirect penalty: a branch target is requested after the delay-slot ack. An exception target is requested the cycle after `flush`, or after the drop ack.
- Reset asserted mid-transaction: all state clears asynchronously, and the outstanding request is abandoned. Memory must tolerate `imem_req` dropping.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - When `fetch_pc[1:0]`≠0, no request is issued.
  - The output register loads `if_valid`=1, `if_inst`=0, `if_addr`=`fetch_pc`, `if_addr_err`=1.
  - Fetching then halts until `flush`.
- Undefined:
  - `imem_addr[1:0]` is forced to 2'b00.
  - `if_addr_err` is tied 0.

## Test plan
- Reset release, memory acks every cycle: requests go to BFC00000, BFC00004, BFC00008. `if_inst` is non-zero from the second cycle, with no bubbles.
- Branch at BFC00010 to 80001000, accepted on the cycle its delay slot is acked: next `imem_addr`=80001000. BFC00014 (delay slot) appears on `if_inst` before 80001000.
- `stall` high for 3 cycles during acks: one instruction lands in skid, then `imem_req` drops. After release, `if_addr` advances by 4 with no loss or duplication.
- `flush` with `exc_pc`=BFC00380 while a request to 8000200C is awaiting a 2-cycle ack: the returned data is discarded and `if_valid` stays 0. The next request is BFC00380.
- `flush` and `branch_flag` in the same cycle: the exception wins, `redir_pend` stays 0, and the next request is `exc_pc`.
- `FETCH_ALIGN_CHECK_EN` defined, branch to 80000002: `if_addr_err`=1, `if_addr`=80000002, no `imem_req` until `flush`.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory request/acknowledge bus used by the
//                fetch stage.
//                  req   - fetch request (master -> memory)
//                  addr  - fetch address, stable while req=1 and no ack
//                  ack   - request completes this cycle (memory -> master)
//                  rdata - instruction word, valid when ack=1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : MIPS instruction-fetch stage. Owns the fetch PC, runs a
//                req/ack handshake with instruction memory, absorbs decode
//                stalls with a one-entry skid buffer, redirects to branch
//                targets after the delay slot and to exception targets at
//                once.
//  Ports       : clk, rst (async, active-low)
//                stall, flush, exc_pc, branch_flag, branch_addr  (decode/CP0)
//                imem        (fetch_unit_if.master, instruction memory bus)
//                if_valid, if_addr, if_inst, if_stall_req, if_addr_err
//  Config      : FETCH_ALIGN_CHECK_EN - when defined, a misaligned fetch PC
//                issues no request; an error entry is handed to decode and
//                fetching halts until flush. When undefined the low two
//                address bits are forced to zero and if_addr_err stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        stall,
    input  wire logic        flush,
    input  wire logic [31:0] exc_pc,
    input  wire logic        branch_flag,
    input  wire logic [31:0] branch_addr,
    fetch_unit_if.master     imem,
    output logic             if_valid,
    output logic [31:0]      if_addr,
    output logic [31:0]      if_inst,
    output logic             if_stall_req,
    output logic             if_addr_err
);

    // HALT is only reachable when the alignment check is compiled in.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [31:0] fetch_pc_q,   fetch_pc_d;
    logic        req_q,        req_d;
    logic [31:0] addr_q,       addr_d;
    logic        out_valid_q,  out_valid_d;
    logic [31:0] out_addr_q,   out_addr_d;
    logic [31:0] out_inst_q,   out_inst_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_addr_q,  skid_addr_d;
    logic [31:0] skid_inst_q,  skid_inst_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_addr_q, redir_addr_d;
    logic        stall_req_q,  stall_req_d;
    logic        addr_err_q,   addr_err_d;

    logic        w_ack;
    logic        w_out_free;
    logic        w_branch_take;
    logic [31:0] w_seq_pc;
    logic        w_issue;
    logic [31:0] w_issue_addr;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_inst_d   = out_inst_q;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_inst_d  = skid_inst_q;
        redir_pend_d = redir_pend_q;
        redir_addr_d = redir_addr_q;
        addr_err_d   = addr_err_q;
        w_issue      = 1'b0;
        w_issue_addr = fetch_pc_q;

        w_ack         = req_q & imem.ack;
        // Output register may be (re)loaded when decode takes it or it is empty.
        w_out_free    = ~stall | ~out_valid_q;
        w_branch_take = branch_flag & out_valid_q & ~stall;

        // Address following an acked request.
        if (w_branch_take) begin
            w_seq_pc = branch_addr;
        end else if (redir_pend_q) begin
            w_seq_pc = redir_addr_q;
        end else begin
            w_seq_pc = fetch_pc_q + 32'd4;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            out_addr_d   = 32'h0;
            out_inst_d   = 32'h0;
            skid_valid_d = 1'b0;
            skid_addr_d  = 32'h0;
            skid_inst_d  = 32'h0;
            redir_pend_d = 1'b0;
            addr_err_d   = 1'b0;
            fetch_pc_d   = exc_pc;
            if (req_q && !imem.ack) begin
                // Request still outstanding: keep it on the bus and throw
                // its data away when it returns.
                state_d = ST_DROP;
                req_d   = 1'b1;
            end else begin
                w_issue      = 1'b1;
                w_issue_addr = exc_pc;
            end
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (!req_q) begin
                        // First cycle out of reset.
                        w_issue      = 1'b1;
                        w_issue_addr = fetch_pc_q;
                    end else if (w_ack) begin
                        if (w_out_free) begin
                            out_valid_d = 1'b1;
                            out_addr_d  = addr_q;
                            out_inst_d  = imem.rdata;
                        end else begin
                            skid_valid_d = 1'b1;
                            skid_addr_d  = addr_q;
                            skid_inst_d  = imem.rdata;
                        end
                        if (!w_branch_take && redir_pend_q) begin
                            redir_pend_d = 1'b0;
                        end
                        fetch_pc_d = w_seq_pc;
                        if (w_out_free) begin
                            w_issue      = 1'b1;
                            w_issue_addr = w_seq_pc;
                        end else begin
                            state_d = ST_HOLD;
                            req_d   = 1'b0;
                        end
                    end else begin
                        if (!stall) begin
                            out_valid_d = 1'b0;
                            out_inst_d  = 32'h0;
                        end
                        // The in-flight request is the delay slot; redirect
                        // once it has been acked.
                        if (w_branch_take) begin
                            redir_pend_d = 1'b1;
                            redir_addr_d = branch_addr;
                        end
                    end
                end

                ST_HOLD: begin
                    if (!stall) begin
                        out_valid_d  = 1'b1;
                        out_addr_d   = skid_addr_q;
                        out_inst_d   = skid_inst_q;
                        skid_valid_d = 1'b0;
                        w_issue      = 1'b1;
                        // The skid entry already holds the delay slot, so a
                        // branch taken now goes straight to its target.
                        w_issue_addr = w_branch_take ? branch_addr : fetch_pc_q;
                    end
                end

                ST_DROP: begin
                    if (imem.ack) begin
                        w_issue      = 1'b1;
                        w_issue_addr = fetch_pc_q;
                    end
                end

                ST_HALT: begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (w_out_free) begin
                        if (!addr_err_q) begin
                            out_valid_d = 1'b1;
                            out_addr_d  = fetch_pc_q;
                            out_inst_d  = 32'h0;
                            addr_err_d  = 1'b1;
                        end else if (!stall) begin
                            out_valid_d = 1'b0;
                            out_inst_d  = 32'h0;
                        end
                    end
`else
                    w_issue      = 1'b1;
                    w_issue_addr = fetch_pc_q;
`endif
                end

                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end

        if (w_issue) begin
            fetch_pc_d = w_issue_addr;
`ifdef FETCH_ALIGN_CHECK_EN
            addr_d = w_issue_addr;
            if (w_issue_addr[1:0] != 2'b00) begin
                state_d = ST_HALT;
                req_d   = 1'b0;
            end else begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
`else
            addr_d  = {w_issue_addr[31:2], 2'b00};
            state_d = ST_FETCH;
            req_d   = 1'b1;
`endif
        end

        stall_req_d = ~out_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            out_valid_q  <= 1'b0;
            out_addr_q   <= 32'h0;
            out_inst_q   <= 32'h0;
            skid_valid_q <= 1'b0;
            skid_addr_q  <= 32'h0;
            skid_inst_q  <= 32'h0;
            redir_pend_q <= 1'b0;
            redir_addr_q <= 32'h0;
            stall_req_q  <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_inst_q   <= out_inst_d;
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_inst_q  <= skid_inst_d;
            redir_pend_q <= redir_pend_d;
            redir_addr_q <= redir_addr_d;
            stall_req_q  <= stall_req_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign imem.req     = req_q;
    assign imem.addr    = addr_q;
    assign if_valid     = out_valid_q;
    assign if_addr      = out_addr_q;
    assign if_inst      = out_inst_q;
    assign if_stall_req = stall_req_q;
    assign if_addr_err  = addr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit. Memory answers
//                combinationally when mem_ready=1 with a data word derived
//                from the address.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] exc_pc;
    logic        branch_flag;
    logic [31:0] branch_addr;
    logic        mem_ready;
    logic        if_valid;
    logic [31:0] if_addr;
    logic [31:0] if_inst;
    logic        if_stall_req;
    logic        if_addr_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    assign bus.ack   = bus.req & mem_ready;
    assign bus.rdata = bus.ack ? inst_of(bus.addr) : 32'h0;

    fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .exc_pc       (exc_pc),
        .branch_flag  (branch_flag),
        .branch_addr  (branch_addr),
        .imem         (bus.master),
        .if_valid     (if_valid),
        .if_addr      (if_addr),
        .if_inst      (if_inst),
        .if_stall_req (if_stall_req),
        .if_addr_err  (if_addr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output register holds a real instruction fetched from address a.
    task automatic check_out(input string tag, input logic [31:0] a);
        check({tag, ".valid"}, 32'(if_valid), 32'd1);
        check({tag, ".addr"},  if_addr, a);
        check({tag, ".inst"},  if_inst, inst_of(a));
    endtask

    task automatic check_bus(input string tag, input logic r, input logic [31:0] a);
        check({tag, ".req"},  32'(bus.req), 32'(r));
        check({tag, ".addr"}, bus.addr, a);
    endtask

    task automatic check_bubble(input string tag);
        check({tag, ".valid"},    32'(if_valid), 32'd0);
        check({tag, ".inst"},     if_inst, 32'h0);
        check({tag, ".stallreq"}, 32'(if_stall_req), 32'd1);
    endtask

    initial begin
        rst         = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        exc_pc      = 32'h0;
        branch_flag = 1'b0;
        branch_addr = 32'h0;
        mem_ready   = 1'b1;

        // ---------------- reset state ----------------
        step();
        step();
        check_bus("rst", 1'b0, 32'hBFC0_0000);
        check("rst.valid",    32'(if_valid), 32'd0);
        check("rst.ifaddr",   if_addr, 32'h0);
        check("rst.inst",     if_inst, 32'h0);
        check("rst.stallreq", 32'(if_stall_req), 32'd0);
        check("rst.err",      32'(if_addr_err), 32'd0);

        // ---------------- streaming, acks every cycle ----------------
        rst = 1'b1;
        step();
        check_bus("first", 1'b1, 32'hBFC0_0000);
        check_bubble("first");
        step();
        check_out("s0", 32'hBFC0_0000);
        check_bus("s0", 1'b1, 32'hBFC0_0004);
        step();
        check_out("s1", 32'hBFC0_0004);
        check_bus("s1", 1'b1, 32'hBFC0_0008);
        step();
        check_out("s2", 32'hBFC0_0008);
        step();
        check_out("s3", 32'hBFC0_000C);
        step();
        check_out("s4", 32'hBFC0_0010);
        check_bus("s4", 1'b1, 32'hBFC0_0014);

        // ---------------- branch, delay slot acked same cycle ----------------
        branch_flag = 1'b1;
        branch_addr = 32'h8000_1000;
        step();
        branch_flag = 1'b0;
        check_out("dslot", 32'hBFC0_0014);
        check_bus("btgt", 1'b1, 32'h8000_1000);
        step();
        check_out("tgt", 32'h8000_1000);
        check_bus("tgt", 1'b1, 32'h8000_1004);

        // ---------------- 3-cycle stall, skid buffer ----------------
        stall = 1'b1;
        step();
        check_out("stall1", 32'h8000_1000);
        check("stall1.req", 32'(bus.req), 32'd0);
        step();
        check_out("stall2", 32'h8000_1000);
        check("stall2.req", 32'(bus.req), 32'd0);
        step();
        check_out("stall3", 32'h8000_1000);
        stall = 1'b0;
        step();
        check_out("skid", 32'h8000_1004);
        check_bus("skid", 1'b1, 32'h8000_1008);
        step();
        check_out("after", 32'h8000_1008);
        check_bus("after", 1'b1, 32'h8000_100C);

        // ---------------- flush while a request waits on a slow ack ----------------
        branch_flag = 1'b1;
        branch_addr = 32'h8000_200C;
        step();
        branch_flag = 1'b0;
        mem_ready   = 1'b0;
        check_out("fl.ds", 32'h8000_100C);
        check_bus("fl.req", 1'b1, 32'h8000_200C);
        step();
        check_bubble("fl.wait");
        flush  = 1'b1;
        exc_pc = 32'hBFC0_0380;
        step();
        flush     = 1'b0;
        mem_ready = 1'b1;
        check_bus("drop", 1'b1, 32'h8000_200C);
        check_bubble("drop");
        step();
        check_bubble("dropack");
        check_bus("exc", 1'b1, 32'hBFC0_0380);
        step();
        check_out("exc", 32'hBFC0_0380);

        // ---------------- flush and branch together ----------------
        flush       = 1'b1;
        exc_pc      = 32'hBFC0_0200;
        branch_flag = 1'b1;
        branch_addr = 32'h8000_4000;
        step();
        flush       = 1'b0;
        branch_flag = 1'b0;
        check_bubble("fb");
        check_bus("fb", 1'b1, 32'hBFC0_0200);
        step();
        check_out("fb1", 32'hBFC0_0200);
        check_bus("fb1", 1'b1, 32'hBFC0_0204);

        // ---------------- PC wrap at 2^32 ----------------
        branch_flag = 1'b1;
        branch_addr = 32'hFFFF_FFF8;
        step();
        branch_flag = 1'b0;
        check_out("w0", 32'hBFC0_0204);
        step();
        check_out("w1", 32'hFFFF_FFF8);
        step();
        check_out("w2", 32'hFFFF_FFFC);
        check_bus("wrap", 1'b1, 32'h0000_0000);

        // ---------------- branch accepted before the delay slot is acked ----------------
        mem_ready   = 1'b0;
        branch_flag = 1'b1;
        branch_addr = 32'h8000_3000;
        step();
        branch_flag = 1'b0;
        mem_ready   = 1'b1;
        check_bubble("rp");
        check_bus("rp", 1'b1, 32'h0000_0000);
        step();
        check_out("rp.ds", 32'h0000_0000);
        check_bus("rp.tgt", 1'b1, 32'h8000_3000);
        step();
        check_out("rp.t", 32'h8000_3000);

        // ---------------- misaligned branch target ----------------
        branch_flag = 1'b1;
        branch_addr = 32'h8000_0002;
        step();
        branch_flag = 1'b0;
        check_out("ma.ds", 32'h8000_3004);
`ifdef FETCH_ALIGN_CHECK_EN
        check("ma.req0", 32'(bus.req), 32'd0);
        step();
        check("ma.valid", 32'(if_valid), 32'd1);
        check("ma.addr",  if_addr, 32'h8000_0002);
        check("ma.inst",  if_inst, 32'h0);
        check("ma.err",   32'(if_addr_err), 32'd1);
        check("ma.req1",  32'(bus.req), 32'd0);
        step();
        step();
        check("ma.req2",  32'(bus.req), 32'd0);
        check("ma.err2",  32'(if_addr_err), 32'd1);
`else
        check_bus("ma.bus", 1'b1, 32'h8000_0000);
        step();
        check_out("ma.out", 32'h8000_0000);
        check("ma.err", 32'(if_addr_err), 32'd0);
`endif
        flush  = 1'b1;
        exc_pc = 32'hBFC0_0380;
        step();
        flush = 1'b0;
        check_bus("rec", 1'b1, 32'hBFC0_0380);
        check("rec.err", 32'(if_addr_err), 32'd0);
        step();
        check_out("rec", 32'hBFC0_0380);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
